// File: rtl/enums.sv
// Shared encodings for mem_responder: FSM states, access unit codes, CLINT word offsets.
// No logic; constants only.
package enums;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UNIT_BYTE = 2'b00,
        UNIT_HALF = 2'b01,
        UNIT_WORD = 2'b10,
        UNIT_BAD  = 2'b11
    } unit_t;

    localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] CLINT_MCYCLE_LO   = 32'h0000_BFF8;
    localparam logic [31:0] CLINT_MCYCLE_HI   = 32'h0000_BFFC;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and combinational read.
// Write on rising clk edge; read is same-cycle; no reset, contents start undefined.
// No backpressure: always accepts a write.
module byte_lane_ram #(
    parameter int WORDS = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: RAM window plus optional timer window (MEM_RESPONDER_CLINT_EN).
// Latency: response WAIT_CYCLES+1 cycles after the request cycle; resp_valid lasts one cycle.
// Backpressure: req_ready is high only in IDLE; requests in WAIT/RESP are ignored.
module mem_responder
    import enums::*;
#(
    parameter int          MEM_WORDS   = 16384,
    parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
    parameter logic [31:0] CLINT_BASE  = 32'h0200_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [1:0]  req_unit,
    output logic        resp_valid,
    output logic [31:0] resp_rd,
    output logic        resp_err,
    input  logic [63:0] mcycle,
    output logic [63:0] mcycle_next_mem,
    output logic        mcycle_we,
    input  logic [63:0] mtimecmp,
    output logic [63:0] mtimecmp_next
);

`ifdef MEM_RESPONDER_CLINT_EN
    localparam bit CLINT_EN = 1'b1;
`else
    localparam bit CLINT_EN = 1'b0;
`endif

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_LD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        lat_en;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wd;
    unit_t       lat_unit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_we   <= 1'b0;
            lat_addr <= 32'd0;
            lat_wd   <= 32'd0;
            lat_unit <= UNIT_BYTE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (lat_en) begin
                lat_we   <= req_we;
                lat_addr <= req_addr;
                lat_wd   <= req_wd;
                lat_unit <= unit_t'(req_unit);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_en    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_en = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address decode on the latched request.
    logic [31:0] ram_off;
    logic [31:0] clint_off;
    logic        ram_hit;
    logic        sel_mtimecmp;
    logic        sel_mcycle;
    logic        clint_sel;
    logic        clint_bad;
    logic        misalign;
    logic        err;

    always_comb begin
        ram_off      = lat_addr - RAM_BASE;
        clint_off    = lat_addr - CLINT_BASE;
        ram_hit      = ({1'b0, ram_off} < RAM_BYTES);
        sel_mtimecmp = CLINT_EN && (clint_off[31:3] == CLINT_MTIMECMP_LO[31:3]);
        sel_mcycle   = CLINT_EN && (clint_off[31:3] == CLINT_MCYCLE_LO[31:3]);
        clint_sel    = sel_mtimecmp || sel_mcycle;
        clint_bad    = clint_sel && ((lat_unit != UNIT_WORD) || (clint_off[1:0] != 2'b00));
        case (lat_unit)
            UNIT_BYTE: misalign = 1'b0;
            UNIT_HALF: misalign = lat_addr[0];
            UNIT_WORD: misalign = (lat_addr[1:0] != 2'b00);
            default:   misalign = 1'b1;
        endcase
        err = misalign || clint_bad || !(ram_hit || clint_sel);
    end

    // RAM lanes: byte enables and write data steered to the addressed lane.
    logic [3:0]  ram_be;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] ram_shift;
    logic [31:0] ram_rd;
    logic        in_resp;

    always_comb begin
        in_resp = (state == RESP);
        case (lat_unit)
            UNIT_BYTE: ram_be = 4'b0001 << lat_addr[1:0];
            UNIT_HALF: ram_be = 4'b0011 << lat_addr[1:0];
            UNIT_WORD: ram_be = 4'b1111;
            default:   ram_be = 4'b0000;
        endcase
        ram_we    = (in_resp && lat_we && ram_hit && !err) ? ram_be : 4'b0000;
        ram_wdata = lat_wd << {lat_addr[1:0], 3'b000};
        ram_shift = ram_rdata >> {lat_addr[1:0], 3'b000};
        case (lat_unit)
            UNIT_BYTE: ram_rd = {24'd0, ram_shift[7:0]};
            UNIT_HALF: ram_rd = {16'd0, ram_shift[15:0]};
            default:   ram_rd = ram_shift;
        endcase
    end

    byte_lane_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_off[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Timer window: one-cycle write strobe in RESP, other half passes through.
    logic        hi_half;
    logic        clint_wr;
    logic [31:0] clint_rd;

    always_comb begin
        hi_half         = clint_off[2];
        clint_wr        = in_resp && lat_we && clint_sel && !err;
        mtimecmp_next   = mtimecmp;
        mcycle_next_mem = mcycle;
        mcycle_we       = 1'b0;
        if (clint_wr && sel_mtimecmp) begin
            if (hi_half) mtimecmp_next = {lat_wd, mtimecmp[31:0]};
            else         mtimecmp_next = {mtimecmp[63:32], lat_wd};
        end
        if (clint_wr && sel_mcycle) begin
            mcycle_we = 1'b1;
            if (hi_half) mcycle_next_mem = {lat_wd, mcycle[31:0]};
            else         mcycle_next_mem = {mcycle[63:32], lat_wd};
        end
        if (sel_mtimecmp) clint_rd = hi_half ? mtimecmp[63:32] : mtimecmp[31:0];
        else              clint_rd = hi_half ? mcycle[63:32]   : mcycle[31:0];
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = in_resp;
        resp_err   = in_resp && err;
        resp_rd    = 32'd0;
        if (in_resp && !lat_we && !err) begin
            resp_rd = ram_hit ? ram_rd : clint_rd;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; expectations queued at acceptance, checked by a response monitor.
module tb_mem_responder;
    localparam int          WC  = 1;
    localparam logic [63:0] MTC = 64'h1111_2222_3333_4444;
    localparam logic [63:0] MCY = 64'h0000_00AA_0000_0055;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wd = 32'd0;
    logic [1:0]  req_unit = 2'b00;
    logic        resp_valid;
    logic [31:0] resp_rd;
    logic        resp_err;
    logic [63:0] mcycle = MCY;
    logic [63:0] mcycle_next_mem;
    logic        mcycle_we;
    logic [63:0] mtimecmp = MTC;
    logic [63:0] mtimecmp_next;

    mem_responder #(.WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wd(req_wd), .req_unit(req_unit),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
        .mcycle(mcycle), .mcycle_next_mem(mcycle_next_mem), .mcycle_we(mcycle_we),
        .mtimecmp(mtimecmp), .mtimecmp_next(mtimecmp_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mwe;
        logic [63:0] mtc;
        logic [63:0] mcy;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_resp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%h expected=%h", nm, tag, act, expv);
        end
    endtask

    // Response monitor: pops one expectation per resp_valid cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                n_resp++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=resp_valid expected=no_response");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rd", e.tag, 64'(resp_rd), 64'(e.rd));
                    chk("resp_err", e.tag, 64'(resp_err), 64'(e.err));
                    chk("mcycle_we", e.tag, 64'(mcycle_we), 64'(e.mwe));
                    chk("mtimecmp_next", e.tag, mtimecmp_next, e.mtc);
                    chk("mcycle_next_mem", e.tag, mcycle_next_mem, e.mcy);
                    chk("latency", e.tag, 64'(cyc - e.cyc), 64'(WC + 1));
                end
            end else begin
                chk("idle_mcycle_we", 0, 64'(mcycle_we), 64'd0);
                chk("idle_mtimecmp_next", 0, mtimecmp_next, MTC);
            end
        end
    end

    task automatic push(input logic [31:0] erd, input logic eerr, input logic emwe,
                        input logic [63:0] emtc, input logic [63:0] emcy, input int tag);
        exp_t e;
        e.rd = erd; e.err = eerr; e.mwe = emwe; e.mtc = emtc; e.mcy = emcy;
        e.cyc = cyc; e.tag = tag;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic drain(input int tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", tag, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] unit, input logic [31:0] erd, input logic eerr,
                         input logic emwe, input logic [63:0] emtc, input logic [63:0] emcy,
                         input int tag);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd; req_unit = unit;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag=%0d actual=ready_low expected=ready_high", tag);
        end else begin
            push(erd, eerr, emwe, emtc, emcy, tag);
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain(tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [1:0] unit,
                      input logic [31:0] erd, input logic eerr, input int tag);
        issue(1'b0, addr, 32'd0, unit, erd, eerr, 1'b0, MTC, MCY, tag);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] unit,
                      input logic eerr, input int tag);
        issue(1'b1, addr, wd, unit, 32'd0, eerr, 1'b0, MTC, MCY, tag);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", 0, 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 0, 64'(resp_valid), 64'd0);
        chk("rst_resp_rd", 0, 64'(resp_rd), 64'd0);
        chk("rst_resp_err", 0, 64'(resp_err), 64'd0);
        chk("rst_mcycle_we", 0, 64'(mcycle_we), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        wr(32'h8000_0000, 32'hDEAD_BEEF, 2'b10, 1'b0, 1);
        rd(32'h8000_0001, 2'b00, 32'h0000_00BE, 1'b0, 2);
        wr(32'h8000_0004, 32'h0000_0000, 2'b10, 1'b0, 3);
        wr(32'h8000_0006, 32'h0000_1234, 2'b01, 1'b0, 4);
        rd(32'h8000_0004, 2'b10, 32'h1234_0000, 1'b0, 5);
        rd(32'h8000_0006, 2'b01, 32'h0000_1234, 1'b0, 6);
        rd(32'h8000_0002, 2'b01, 32'h0000_DEAD, 1'b0, 7);
        rd(32'h8000_0003, 2'b00, 32'h0000_00DE, 1'b0, 8);
        rd(32'h8000_0002, 2'b10, 32'h0, 1'b1, 9);
        wr(32'h8000_0002, 32'hFFFF_FFFF, 2'b10, 1'b1, 10);
        rd(32'h8000_0001, 2'b01, 32'h0, 1'b1, 11);
        rd(32'h8000_0000, 2'b11, 32'h0, 1'b1, 12);
        wr(32'h8000_0000, 32'h0000_0000, 2'b11, 1'b1, 13);
        rd(32'h8000_0000, 2'b10, 32'hDEAD_BEEF, 1'b0, 14);
        wr(32'h8000_0001, 32'h1234_565A, 2'b00, 1'b0, 15);
        rd(32'h8000_0000, 2'b10, 32'hDEAD_5AEF, 1'b0, 16);
        wr(32'h8000_FFFC, 32'h0BAD_F00D, 2'b10, 1'b0, 17);
        rd(32'h8000_FFFC, 2'b10, 32'h0BAD_F00D, 1'b0, 18);
        rd(32'h8001_0000, 2'b10, 32'h0, 1'b1, 19);
        rd(32'h7FFF_FFFC, 2'b10, 32'h0, 1'b1, 20);
        wr(32'h9000_0000, 32'h1, 2'b10, 1'b1, 21);

`ifdef MEM_RESPONDER_CLINT_EN
        issue(1'b1, 32'h0200_4000, 32'h0000_0100, 2'b10, 32'h0, 1'b0, 1'b0,
              {32'h1111_2222, 32'h0000_0100}, MCY, 22);
        issue(1'b1, 32'h0200_BFF8, 32'h0000_0077, 2'b10, 32'h0, 1'b0, 1'b1,
              MTC, {32'h0000_00AA, 32'h0000_0077}, 23);
        issue(1'b1, 32'h0200_BFFC, 32'h0000_0005, 2'b10, 32'h0, 1'b0, 1'b1,
              MTC, {32'h0000_0005, 32'h0000_0055}, 24);
        rd(32'h0200_4004, 2'b10, 32'h1111_2222, 1'b0, 25);
        rd(32'h0200_4000, 2'b00, 32'h0, 1'b1, 26);
        rd(32'h0200_BFF8, 2'b10, 32'h0000_0055, 1'b0, 27);
`else
        wr(32'h0200_4000, 32'h0000_0100, 2'b10, 1'b1, 22);
        rd(32'h0200_BFF8, 2'b10, 32'h0, 1'b1, 23);
`endif

        // Reset during WAIT of a write: aborted, no response, old data kept.
        wr(32'h8000_0008, 32'hCAFE_F00D, 2'b10, 1'b0, 30);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0008;
        req_wd = 32'h1111_1111; req_unit = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", 31, 64'(resp_valid), 64'd0);
        chk("midrst_req_ready", 31, 64'(req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rd(32'h8000_0008, 2'b10, 32'hCAFE_F00D, 1'b0, 32);

        // req_valid held high: one response per accepted request.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0000; req_unit = 2'b10;
        for (int i = 0; i < 2 * (WC + 2); i++) begin
            if (req_ready) push(32'hDEAD_5AEF, 1'b0, 1'b0, MTC, MCY, 40 + i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain(50);
        repeat (4) @(negedge clk);
        chk("resp_count", 51, 64'(n_resp), 64'(n_push));
        chk("sb_empty", 52, 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
